// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: instruction prefetch FIFO with a single-outstanding fetch FSM
// Ports:
//   clock, reset          - posedge clock, async active-high reset
//   mem_req/mem_addr      - word-address fetch request, held until mem_ack
//   mem_ack/mem_rdata     - memory accept strobe and returned instruction word
//   redirect/redirect_pc  - flush the queue and refetch from a new byte address
//   stall                 - consumer holds the head entry
//   ir/ir_pc4/ir_valid    - head instruction, its byte address + 4, non-empty flag
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] ir,
  output logic [31:0] ir_pc4,
  output logic        ir_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t        r_state;
  logic [29:0]   r_fpc;
  logic [29:0]   r_daddr;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic [31:0]   r_data [DEPTH];
  logic [29:0]   r_pc   [DEPTH];
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_next_count;
  assign w_push       = r_state == REQ && mem_ack && !redirect;
  assign w_pop        = ir_valid && !stall && !redirect;
  assign w_next_count = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign ir_valid = r_count != '0;
  assign ir       = ir_valid ? r_data[r_rd] : '0;
  assign ir_pc4   = ir_valid ? {r_pc[r_rd] + 30'd1, 2'b00} : '0;
  assign mem_req  = r_state != IDLE;
  assign mem_addr = r_state == REQ ? r_fpc : r_state == DISCARD ? r_daddr : '0;
  always_ff @(posedge clock)
    if (w_push) begin
      r_data[r_wr] <= mem_rdata;
      r_pc[r_wr]   <= r_fpc;
    end
  // A redirect while a request is still unacknowledged keeps that request on
  // the bus (in DISCARD) so the memory handshake is never broken.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_fpc   <= RESET_PC[31:2];
      r_daddr <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_fpc   <= redirect_pc[31:2];
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_state <= r_state != IDLE && !mem_ack ? DISCARD : REQ;
      if (r_state == REQ) r_daddr <= r_fpc;
    end else begin
      r_fpc   <= w_push ? r_fpc + 30'd1 : r_fpc;
      r_wr    <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd    <= w_pop ? r_rd + AW'(1) : r_rd;
      r_count <= w_next_count;
      r_state <= r_state == IDLE ? (r_count < FULL ? REQ : IDLE) :
                 r_state == REQ  ? (w_push && w_next_count == FULL ? IDLE : REQ) :
                 (mem_ack ? REQ : DISCARD);
    end
endmodule
